// File: rtl/mp1000_pkg.sv
// Shared MP1000 definitions: upload FSM states, ioctl index and RAM address width.
package mp1000_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        REQ   = 2'd2,
        FETCH = 2'd3
    } upload_state_t;

    localparam logic [7:0]  MP1000_IDX_UPLOAD = 8'h02;
    localparam int unsigned MP1000_RAM_AW     = 16;

endpackage

// File: rtl/mp1000_ioctl_upload.sv
// MiSTer ioctl upload server: reads system RAM through dpram port A and
// returns bytes on ioctl_din, stalling the HPS with ioctl_wait meanwhile.
//
// Ports:
//   clk_sys, reset              system clock, synchronous active-high reset
//   ioctl_upload/index/rd/addr  HPS upload session, read strobe and offset
//   ioctl_din, ioctl_wait       returned byte, HPS hold-off
//   ram_req/ram_gnt             port-A arbitration handshake
//   ram_ad, ram_q               port-A address and read data
//   err_overrun                 sticky: read strobe arrived while busy
//   upload_sum                  session checksum of delivered bytes
//
// Build option: define MP1000_UPLOAD_CHECKSUM_EN to build the checksum
// adder; otherwise upload_sum reads 8'h00.
module mp1000_ioctl_upload
    import mp1000_pkg::*;
#(
    parameter logic [7:0]  UPLOAD_INDEX = MP1000_IDX_UPLOAD,
    parameter logic [15:0] BASE_ADDR    = 16'h0000,
    parameter logic [16:0] SIZE         = 17'h10000,
    parameter int unsigned RAM_LATENCY  = 1
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic                     ioctl_upload,
    input  logic [7:0]               ioctl_index,
    input  logic                     ioctl_rd,
    input  logic [24:0]              ioctl_addr,
    output logic [7:0]               ioctl_din,
    output logic                     ioctl_wait,
    output logic                     ram_req,
    input  logic                     ram_gnt,
    output logic [MP1000_RAM_AW-1:0] ram_ad,
    input  logic [7:0]               ram_q,
    output logic                     err_overrun,
    output logic [7:0]               upload_sum
);

    localparam int unsigned CNT_W = 2;

    upload_state_t              state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [7:0]                 din_q, din_d;
    logic                       wait_q, wait_d;
    logic                       req_q, req_d;
    logic [MP1000_RAM_AW-1:0]   ad_q, ad_d;
    logic                       ovr_q, ovr_d;
    logic                       deliver;
    logic                       sum_clr;
    logic                       in_range;

    // Range check spans the full 25-bit offset, not just the RAM-sized part.
    assign in_range = (ioctl_addr < 25'(SIZE));

    // State and registered outputs.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            din_q   <= 8'h00;
            wait_q  <= 1'b0;
            req_q   <= 1'b0;
            ad_q    <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            wait_q  <= wait_d;
            req_q   <= req_d;
            ad_q    <= ad_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next state and next output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        din_d   = din_q;
        ad_d    = ad_q;
        ovr_d   = ovr_q;
        deliver = 1'b0;
        sum_clr = 1'b0;

        if (!ioctl_upload) begin
            // Session drop discards any in-flight read; din keeps its value.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ioctl_index == UPLOAD_INDEX) begin
                        state_d = ARM;
                        ovr_d   = 1'b0;
                        sum_clr = 1'b1;
                    end
                end
                ARM: begin
                    if (ioctl_rd) begin
                        if (in_range) begin
                            ad_d    = BASE_ADDR + ioctl_addr[15:0];
                            state_d = REQ;
                        end else begin
                            din_d   = 8'hFF;
                            deliver = 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (ioctl_rd) ovr_d = 1'b1;
                    if (ram_gnt) begin
                        state_d = FETCH;
                        cnt_d   = CNT_W'(RAM_LATENCY);
                    end
                end
                FETCH: begin
                    if (ioctl_rd) ovr_d = 1'b1;
                    // Data is captured on the edge where the counter hits zero.
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        din_d   = ram_q;
                        deliver = 1'b1;
                        state_d = ARM;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Handshake outputs follow the next state so they are registered.
        wait_d = (state_d == REQ) || (state_d == FETCH);
        req_d  = (state_d == REQ);
    end

    assign ioctl_din   = din_q;
    assign ioctl_wait  = wait_q;
    assign ram_req     = req_q;
    assign ram_ad      = ad_q;
    assign err_overrun = ovr_q;

`ifdef MP1000_UPLOAD_CHECKSUM_EN
    logic [7:0] sum_q;

    // Modulo-256 sum of every byte delivered this session, fills included.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sum_q <= 8'h00;
        end else if (sum_clr) begin
            sum_q <= 8'h00;
        end else if (deliver) begin
            sum_q <= sum_q + din_d;
        end
    end

    assign upload_sum = sum_q;
`else
    logic unused_sum;
    assign unused_sum = &{1'b0, deliver, sum_clr};
    assign upload_sum = 8'h00;
`endif

endmodule

// File: tb/tb_mp1000_ioctl_upload.sv
// Directed bench for mp1000_ioctl_upload with a RAM model and a byte scoreboard.
module tb_mp1000_ioctl_upload;
    import mp1000_pkg::*;

    localparam logic [15:0] BASE_P = 16'hFF80;
    localparam logic [16:0] SIZE_P = 17'h0200;
    localparam int          LAT_P  = 1;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        ram_req;
    logic        ram_gnt;
    logic [15:0] ram_ad;
    logic [7:0]  ram_q = 8'h00;
    logic        err_overrun;
    logic [7:0]  upload_sum;

    logic [7:0]  mem [0:65535];
    logic [7:0]  sb [$];
    logic [7:0]  model_sum;
    logic [7:0]  last_din;
    int          n_cmp = 0;
    int          n_err = 0;

    mp1000_ioctl_upload #(
        .UPLOAD_INDEX(8'h02),
        .BASE_ADDR   (BASE_P),
        .SIZE        (SIZE_P),
        .RAM_LATENCY (LAT_P)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ioctl_upload(ioctl_upload),
        .ioctl_index (ioctl_index),
        .ioctl_rd    (ioctl_rd),
        .ioctl_addr  (ioctl_addr),
        .ioctl_din   (ioctl_din),
        .ioctl_wait  (ioctl_wait),
        .ram_req     (ram_req),
        .ram_gnt     (ram_gnt),
        .ram_ad      (ram_ad),
        .ram_q       (ram_q),
        .err_overrun (err_overrun),
        .upload_sum  (upload_sum)
    );

    always #5 clk_sys = ~clk_sys;

    // One-cycle-latency synchronous RAM on port A.
    always @(posedge clk_sys) ram_q <= mem[ram_ad];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sum_exp();
`ifdef MP1000_UPLOAD_CHECKSUM_EN
        return model_sum;
`else
        return 8'h00;
`endif
    endfunction

    // Pop the oldest expected byte and compare against the delivered data.
    task automatic score(input string tag);
        logic [7:0] e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            model_sum = model_sum + e;
            last_din  = e;
            check({tag, "_din"}, 32'(ioctl_din), 32'(e));
            check({tag, "_sum"}, 32'(upload_sum), 32'(sum_exp()));
        end
    endtask

    // Issue one read, grant after gdly REQ cycles, count wait/req cycles.
    task automatic do_read(input string tag, input logic [24:0] off, input int gdly);
        bit fill;
        int wc, rc;
        logic [15:0] a;
        fill = (off >= 25'(SIZE_P));
        a    = BASE_P + off[15:0];
        sb.push_back(fill ? 8'hFF : mem[a]);
        @(negedge clk_sys);
        ioctl_rd   = 1'b1;
        ioctl_addr = off;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        wc = 0;
        rc = 0;
        for (int i = 0; i < 64; i++) begin
            if (!ioctl_wait) break;
            wc++;
            if (ram_req) begin
                rc++;
                ram_gnt = (rc > gdly);
            end else begin
                ram_gnt = 1'b0;
            end
            @(negedge clk_sys);
        end
        ram_gnt = 1'b0;
        check({tag, "_wait_cycles"}, 32'(wc), fill ? 32'd0 : 32'(gdly + 1 + LAT_P));
        check({tag, "_req_cycles"},  32'(rc), fill ? 32'd0 : 32'(gdly + 1));
        score(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
        mem[16'h0080] = 8'hA5;
        mem[16'hFF90] = 8'h01;
        mem[16'hFF91] = 8'h02;
        model_sum    = 8'h00;
        last_din     = 8'h00;
        reset        = 1'b1;
        ioctl_upload = 1'b0;
        ioctl_index  = 8'h00;
        ioctl_rd     = 1'b0;
        ioctl_addr   = '0;
        ram_gnt      = 1'b0;

        // Reset values.
        repeat (2) @(negedge clk_sys);
        check("rst_din",   32'(ioctl_din),   32'h00);
        check("rst_wait",  32'(ioctl_wait),  32'd0);
        check("rst_req",   32'(ram_req),     32'd0);
        check("rst_ad",    32'(ram_ad),      32'h0000);
        check("rst_ovr",   32'(err_overrun), 32'd0);
        check("rst_sum",   32'(upload_sum),  32'h00);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        reset = 1'b0;

        // Foreign index must not open a session.
        ioctl_upload = 1'b1;
        ioctl_index  = 8'h03;
        @(negedge clk_sys);
        @(negedge clk_sys);
        check("wrong_idx_state", 32'(dut.state_q), 32'(IDLE));

        // Open a session.
        ioctl_index = 8'h02;
        @(negedge clk_sys);
        check("open_state", 32'(dut.state_q), 32'(ARM));
        model_sum = 8'h00;

        // Offset 0x100 wraps to RAM 0x0080 (BASE 0xFF80).
        do_read("rd_a5", 25'h0000100, 0);
        check("rd_a5_ad", 32'(ram_ad), 32'h0080);
        do_read("rd_gnt5", 25'h0000120, 5);
        do_read("rd_fill", 25'h0000200, 0);
        do_read("rd_fill_hi", 25'h1000100, 0);
        do_read("rd_last", 25'h00001FF, 2);

        // Overrun: second strobe in FETCH is ignored, first read completes.
        sb.push_back(mem[16'(BASE_P + 16'h0030)]);
        @(negedge clk_sys);
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'h0000030;
        ram_gnt    = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        @(negedge clk_sys);
        check("ovr_in_fetch", 32'(dut.state_q), 32'(FETCH));
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'h0000031;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        ram_gnt  = 1'b0;
        check("ovr_wait",  32'(ioctl_wait),  32'd0);
        check("ovr_flag",  32'(err_overrun), 32'd1);
        score("ovr");
        @(negedge clk_sys);
        check("ovr_ignored_wait", 32'(ioctl_wait), 32'd0);
        check("ovr_ignored_req",  32'(ram_req),    32'd0);

        // Session drop in FETCH discards the read.
        @(negedge clk_sys);
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'h0000040;
        ram_gnt    = 1'b1;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        @(negedge clk_sys);
        ioctl_upload = 1'b0;
        ram_gnt      = 1'b0;
        @(negedge clk_sys);
        check("drop_wait",  32'(ioctl_wait),  32'd0);
        check("drop_req",   32'(ram_req),     32'd0);
        check("drop_state", 32'(dut.state_q), 32'(IDLE));
        check("drop_din",   32'(ioctl_din),   32'(last_din));

        // New session clears overrun and checksum.
        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        check("reopen_state", 32'(dut.state_q), 32'(ARM));
        check("reopen_ovr",   32'(err_overrun), 32'd0);
        check("reopen_sum",   32'(upload_sum),  32'h00);
        model_sum = 8'h00;

        // Checksum over 0x01, 0xFF fill, 0x02.
        do_read("sum1", 25'h0000010, 0);
        do_read("sum2", 25'h0000200, 0);
        do_read("sum3", 25'h0000011, 0);
`ifdef MP1000_UPLOAD_CHECKSUM_EN
        check("sum_final", 32'(upload_sum), 32'h02);
`else
        check("sum_final", 32'(upload_sum), 32'h00);
`endif

        // Reset while a read waits for grant.
        @(negedge clk_sys);
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'h0000050;
        ram_gnt    = 1'b0;
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        check("rstmid_req_before", 32'(ram_req), 32'd1);
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        check("rstmid_wait",  32'(ioctl_wait),  32'd0);
        check("rstmid_req",   32'(ram_req),     32'd0);
        check("rstmid_din",   32'(ioctl_din),   32'h00);
        check("rstmid_ad",    32'(ram_ad),      32'h0000);
        check("rstmid_state", 32'(dut.state_q), 32'(IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
